// File: rtl/perfcnt_arb_pkg.sv
// Shared constants for the perf-counter AXI4-Lite arbiter: FSM state codes and port ids.
package perfcnt_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t R_IDLE = 2'd0;
    localparam arb_state_t R_ADDR = 2'd1;
    localparam arb_state_t R_DATA = 2'd2;

    localparam arb_state_t W_IDLE = 2'd0;
    localparam arb_state_t W_REQ  = 2'd1;
    localparam arb_state_t W_RESP = 2'd2;

    localparam logic PORT_S0 = 1'b0;
    localparam logic PORT_S1 = 1'b1;

endpackage

// File: rtl/perfcnt_arb_pick.sv
// 2-way combinational picker: round-robin against the last owner, or fixed s0
// priority when PERFCNT_ARB_FIXED_PRIO_EN is defined.
module perfcnt_arb_pick
    import perfcnt_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_winner
);

    // Resolve the winner; with no request the last owner is held.
    always_comb begin
        o_winner = i_last;
        case (i_req)
            2'b01:   o_winner = PORT_S0;
            2'b10:   o_winner = PORT_S1;
`ifdef PERFCNT_ARB_FIXED_PRIO_EN
            2'b11:   o_winner = PORT_S0;
`else
            2'b11:   o_winner = ~i_last;
`endif
            default: o_winner = i_last;
        endcase
    end

endmodule

// File: rtl/perfcnt_axil_arb.sv
// 2:1 AXI4-Lite arbiter in front of the perf-counter slave; read and write arbitrated
// independently, one outstanding transaction per channel. Option: PERFCNT_ARB_FIXED_PRIO_EN.
module perfcnt_axil_arb
    import perfcnt_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     s0_axilite_awaddr,
    input  logic [2:0]                s0_axilite_awprot,
    input  logic                      s0_axilite_awvalid,
    output logic                      s0_axilite_awready,
    input  logic [DATA_WIDTH-1:0]     s0_axilite_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s0_axilite_wstrb,
    input  logic                      s0_axilite_wvalid,
    output logic                      s0_axilite_wready,
    output logic [1:0]                s0_axilite_bresp,
    output logic                      s0_axilite_bvalid,
    input  logic                      s0_axilite_bready,
    input  logic [ADDR_WIDTH-1:0]     s0_axilite_araddr,
    input  logic [2:0]                s0_axilite_arprot,
    input  logic                      s0_axilite_arvalid,
    output logic                      s0_axilite_arready,
    output logic [DATA_WIDTH-1:0]     s0_axilite_rdata,
    output logic [1:0]                s0_axilite_rresp,
    output logic                      s0_axilite_rvalid,
    input  logic                      s0_axilite_rready,
    input  logic [ADDR_WIDTH-1:0]     s1_axilite_awaddr,
    input  logic [2:0]                s1_axilite_awprot,
    input  logic                      s1_axilite_awvalid,
    output logic                      s1_axilite_awready,
    input  logic [DATA_WIDTH-1:0]     s1_axilite_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s1_axilite_wstrb,
    input  logic                      s1_axilite_wvalid,
    output logic                      s1_axilite_wready,
    output logic [1:0]                s1_axilite_bresp,
    output logic                      s1_axilite_bvalid,
    input  logic                      s1_axilite_bready,
    input  logic [ADDR_WIDTH-1:0]     s1_axilite_araddr,
    input  logic [2:0]                s1_axilite_arprot,
    input  logic                      s1_axilite_arvalid,
    output logic                      s1_axilite_arready,
    output logic [DATA_WIDTH-1:0]     s1_axilite_rdata,
    output logic [1:0]                s1_axilite_rresp,
    output logic                      s1_axilite_rvalid,
    input  logic                      s1_axilite_rready,
    output logic [ADDR_WIDTH-1:0]     m_axilite_awaddr,
    output logic [2:0]                m_axilite_awprot,
    output logic                      m_axilite_awvalid,
    input  logic                      m_axilite_awready,
    output logic [DATA_WIDTH-1:0]     m_axilite_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axilite_wstrb,
    output logic                      m_axilite_wvalid,
    input  logic                      m_axilite_wready,
    input  logic [1:0]                m_axilite_bresp,
    input  logic                      m_axilite_bvalid,
    output logic                      m_axilite_bready,
    output logic [ADDR_WIDTH-1:0]     m_axilite_araddr,
    output logic [2:0]                m_axilite_arprot,
    output logic                      m_axilite_arvalid,
    input  logic                      m_axilite_arready,
    input  logic [DATA_WIDTH-1:0]     m_axilite_rdata,
    input  logic [1:0]                m_axilite_rresp,
    input  logic                      m_axilite_rvalid,
    output logic                      m_axilite_rready,
    output logic                      rd_grant,
    output logic                      wr_grant
);

    arb_state_t r_rd_state;
    arb_state_t r_wr_state;
    logic       r_rd_grant;
    logic       r_wr_grant;
    logic       r_aw_done;
    logic       r_w_done;

    logic [1:0] w_rd_req;
    logic [1:0] w_wr_req;
    logic       w_rd_win;
    logic       w_wr_win;
    logic       w_rd_addr_ph;
    logic       w_rd_data_ph;
    logic       w_wr_req_ph;
    logic       w_wr_resp_ph;
    logic       w_ar_fire;
    logic       w_r_fire;
    logic       w_aw_fire;
    logic       w_w_fire;
    logic       w_b_fire;
    logic       w_aw_ok;
    logic       w_w_ok;

    assign w_rd_req = {s1_axilite_arvalid, s0_axilite_arvalid};
    assign w_wr_req = {s1_axilite_awvalid | s1_axilite_wvalid,
                       s0_axilite_awvalid | s0_axilite_wvalid};

    perfcnt_arb_pick u_rd_pick (
        .i_req    (w_rd_req),
        .i_last   (r_rd_grant),
        .o_winner (w_rd_win)
    );

    perfcnt_arb_pick u_wr_pick (
        .i_req    (w_wr_req),
        .i_last   (r_wr_grant),
        .o_winner (w_wr_win)
    );

    assign w_rd_addr_ph = (r_rd_state == R_ADDR);
    assign w_rd_data_ph = (r_rd_state == R_DATA);
    assign w_wr_req_ph  = (r_wr_state == W_REQ);
    assign w_wr_resp_ph = (r_wr_state == W_RESP);

    // Master-side valids depend only on state and slave-side valids, never on m_*ready.
    assign m_axilite_araddr  = (r_rd_grant == PORT_S1) ? s1_axilite_araddr : s0_axilite_araddr;
    assign m_axilite_arprot  = (r_rd_grant == PORT_S1) ? s1_axilite_arprot : s0_axilite_arprot;
    assign m_axilite_arvalid = w_rd_addr_ph &
                               ((r_rd_grant == PORT_S1) ? s1_axilite_arvalid : s0_axilite_arvalid);
    assign m_axilite_rready  = w_rd_data_ph &
                               ((r_rd_grant == PORT_S1) ? s1_axilite_rready : s0_axilite_rready);

    assign s0_axilite_arready = w_rd_addr_ph & (r_rd_grant == PORT_S0) & m_axilite_arready;
    assign s1_axilite_arready = w_rd_addr_ph & (r_rd_grant == PORT_S1) & m_axilite_arready;
    assign s0_axilite_rvalid  = w_rd_data_ph & (r_rd_grant == PORT_S0) & m_axilite_rvalid;
    assign s1_axilite_rvalid  = w_rd_data_ph & (r_rd_grant == PORT_S1) & m_axilite_rvalid;
    assign s0_axilite_rdata   = m_axilite_rdata;
    assign s1_axilite_rdata   = m_axilite_rdata;
    assign s0_axilite_rresp   = m_axilite_rresp;
    assign s1_axilite_rresp   = m_axilite_rresp;

    assign w_ar_fire = m_axilite_arvalid & m_axilite_arready;
    assign w_r_fire  = m_axilite_rvalid & m_axilite_rready;

    // AW and W are forwarded independently; each is masked once it has completed.
    assign m_axilite_awaddr  = (r_wr_grant == PORT_S1) ? s1_axilite_awaddr : s0_axilite_awaddr;
    assign m_axilite_awprot  = (r_wr_grant == PORT_S1) ? s1_axilite_awprot : s0_axilite_awprot;
    assign m_axilite_awvalid = w_wr_req_ph & ~r_aw_done &
                               ((r_wr_grant == PORT_S1) ? s1_axilite_awvalid : s0_axilite_awvalid);
    assign m_axilite_wdata   = (r_wr_grant == PORT_S1) ? s1_axilite_wdata : s0_axilite_wdata;
    assign m_axilite_wstrb   = (r_wr_grant == PORT_S1) ? s1_axilite_wstrb : s0_axilite_wstrb;
    assign m_axilite_wvalid  = w_wr_req_ph & ~r_w_done &
                               ((r_wr_grant == PORT_S1) ? s1_axilite_wvalid : s0_axilite_wvalid);
    assign m_axilite_bready  = w_wr_resp_ph &
                               ((r_wr_grant == PORT_S1) ? s1_axilite_bready : s0_axilite_bready);

    assign s0_axilite_awready = w_wr_req_ph & ~r_aw_done & (r_wr_grant == PORT_S0) & m_axilite_awready;
    assign s1_axilite_awready = w_wr_req_ph & ~r_aw_done & (r_wr_grant == PORT_S1) & m_axilite_awready;
    assign s0_axilite_wready  = w_wr_req_ph & ~r_w_done & (r_wr_grant == PORT_S0) & m_axilite_wready;
    assign s1_axilite_wready  = w_wr_req_ph & ~r_w_done & (r_wr_grant == PORT_S1) & m_axilite_wready;
    assign s0_axilite_bvalid  = w_wr_resp_ph & (r_wr_grant == PORT_S0) & m_axilite_bvalid;
    assign s1_axilite_bvalid  = w_wr_resp_ph & (r_wr_grant == PORT_S1) & m_axilite_bvalid;
    assign s0_axilite_bresp   = m_axilite_bresp;
    assign s1_axilite_bresp   = m_axilite_bresp;

    assign w_aw_fire = m_axilite_awvalid & m_axilite_awready;
    assign w_w_fire  = m_axilite_wvalid & m_axilite_wready;
    assign w_b_fire  = m_axilite_bvalid & m_axilite_bready;
    assign w_aw_ok   = r_aw_done | w_aw_fire;
    assign w_w_ok    = r_w_done | w_w_fire;

    assign rd_grant = r_rd_grant;
    assign wr_grant = r_wr_grant;

    // Read FSM; the grant is registered in R_IDLE and held for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_state <= R_IDLE;
            r_rd_grant <= PORT_S1;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (|w_rd_req) begin
                        r_rd_grant <= w_rd_win;
                        r_rd_state <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (w_ar_fire) begin
                        r_rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (w_r_fire) begin
                        r_rd_state <= R_IDLE;
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    // Write FSM; the response phase starts once both AW and W have been accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_state <= W_IDLE;
            r_wr_grant <= PORT_S1;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (|w_wr_req) begin
                        r_wr_grant <= w_wr_win;
                        r_wr_state <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (w_aw_ok && w_w_ok) begin
                        r_aw_done  <= 1'b0;
                        r_w_done   <= 1'b0;
                        r_wr_state <= W_RESP;
                    end else begin
                        if (w_aw_fire) begin
                            r_aw_done <= 1'b1;
                        end
                        if (w_w_fire) begin
                            r_w_done <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (w_b_fire) begin
                        r_wr_state <= W_IDLE;
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perfcnt_axil_arb.sv
// Self-checking bench for perfcnt_axil_arb: directed scenarios plus randomized traffic
// against a memory-level reference model and a behavioural perf-counter slave.
module tb_perfcnt_axil_arb;

    localparam int BUDGET = 200;
`ifdef PERFCNT_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        s_awvalid [2], s_wvalid [2], s_bready [2], s_arvalid [2], s_rready [2];
    logic [31:0] s_awaddr [2], s_wdata [2], s_araddr [2];
    logic [2:0]  s_awprot [2], s_arprot [2];
    logic [3:0]  s_wstrb [2];
    logic        s_awready [2], s_wready [2], s_bvalid [2], s_arready [2], s_rvalid [2];
    logic [1:0]  s_bresp [2], s_rresp [2];
    logic [31:0] s_rdata [2];

    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic        rd_grant, wr_grant;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    bit rd_abort = 1'b0, rd_hold = 1'b0, rd_drop = 1'b0;
    bit rd_busy [2];
    bit wr_busy [2];
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, dup_aw = 0, dup_w = 0;
    int rd_order [$];
    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    wire [14:0] all_vr = {s_arready[0], s_arready[1], s_rvalid[0], s_rvalid[1],
                          s_awready[0], s_awready[1], s_wready[0], s_wready[1],
                          s_bvalid[0], s_bvalid[1], m_arvalid, m_rready,
                          m_awvalid, m_wvalid, m_bready};

    perfcnt_axil_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_axilite_awaddr(s_awaddr[0]), .s0_axilite_awprot(s_awprot[0]),
        .s0_axilite_awvalid(s_awvalid[0]), .s0_axilite_awready(s_awready[0]),
        .s0_axilite_wdata(s_wdata[0]), .s0_axilite_wstrb(s_wstrb[0]),
        .s0_axilite_wvalid(s_wvalid[0]), .s0_axilite_wready(s_wready[0]),
        .s0_axilite_bresp(s_bresp[0]), .s0_axilite_bvalid(s_bvalid[0]),
        .s0_axilite_bready(s_bready[0]),
        .s0_axilite_araddr(s_araddr[0]), .s0_axilite_arprot(s_arprot[0]),
        .s0_axilite_arvalid(s_arvalid[0]), .s0_axilite_arready(s_arready[0]),
        .s0_axilite_rdata(s_rdata[0]), .s0_axilite_rresp(s_rresp[0]),
        .s0_axilite_rvalid(s_rvalid[0]), .s0_axilite_rready(s_rready[0]),
        .s1_axilite_awaddr(s_awaddr[1]), .s1_axilite_awprot(s_awprot[1]),
        .s1_axilite_awvalid(s_awvalid[1]), .s1_axilite_awready(s_awready[1]),
        .s1_axilite_wdata(s_wdata[1]), .s1_axilite_wstrb(s_wstrb[1]),
        .s1_axilite_wvalid(s_wvalid[1]), .s1_axilite_wready(s_wready[1]),
        .s1_axilite_bresp(s_bresp[1]), .s1_axilite_bvalid(s_bvalid[1]),
        .s1_axilite_bready(s_bready[1]),
        .s1_axilite_araddr(s_araddr[1]), .s1_axilite_arprot(s_arprot[1]),
        .s1_axilite_arvalid(s_arvalid[1]), .s1_axilite_arready(s_arready[1]),
        .s1_axilite_rdata(s_rdata[1]), .s1_axilite_rresp(s_rresp[1]),
        .s1_axilite_rvalid(s_rvalid[1]), .s1_axilite_rready(s_rready[1]),
        .m_axilite_awaddr(m_awaddr), .m_axilite_awprot(m_awprot),
        .m_axilite_awvalid(m_awvalid), .m_axilite_awready(m_awready),
        .m_axilite_wdata(m_wdata), .m_axilite_wstrb(m_wstrb),
        .m_axilite_wvalid(m_wvalid), .m_axilite_wready(m_wready),
        .m_axilite_bresp(m_bresp), .m_axilite_bvalid(m_bvalid), .m_axilite_bready(m_bready),
        .m_axilite_araddr(m_araddr), .m_axilite_arprot(m_arprot),
        .m_axilite_arvalid(m_arvalid), .m_axilite_arready(m_arready),
        .m_axilite_rdata(m_rdata), .m_axilite_rresp(m_rresp),
        .m_axilite_rvalid(m_rvalid), .m_axilite_rready(m_rready),
        .rd_grant(rd_grant), .wr_grant(wr_grant)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] v;
        v = old;
        for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        return v;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : dflt(a);
    endfunction

    // Perf-counter slave, read side: random arready, random read latency.
    initial begin
        logic [31:0] a;
        int n;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'd0; m_rresp = 2'd0;
        forever begin
            @(negedge clk);
            if (rst_n && m_arvalid && m_arready) begin
                a = m_araddr;
                ar_cnt++;
                @(posedge clk); #1 m_arready = 1'b0;
                repeat (int'($urandom_range(0, 2))) begin @(posedge clk); #1; end
                while (rd_hold) begin @(posedge clk); #1; end
                if (!rd_drop) begin
                    m_rvalid = 1'b1; m_rdata = slv_rd(a);
                    m_rresp = a[6] ? 2'b10 : 2'b00;
                    n = 0;
                    do begin @(negedge clk); n++; end while (!m_rready && n < BUDGET);
                    if (!m_rready) chk("slv_rready_timeout", 32'd1, 32'd0);
                    @(posedge clk); #1 m_rvalid = 1'b0;
                end
            end else begin
                @(posedge clk); #1 m_arready = ($urandom_range(0, 1) == 1);
            end
        end
    end

    // Perf-counter slave, write side: AW and W accepted independently, then B.
    initial begin
        logic [31:0] wa, wd;
        logic [3:0] ws;
        bit got_aw, got_w;
        int n;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'd0;
        forever begin
            got_aw = 1'b0; got_w = 1'b0;
            while (!(got_aw && got_w)) begin
                @(negedge clk);
                if (rst_n) begin
                    if (got_aw && m_awvalid) dup_aw++;
                    if (got_w && m_wvalid) dup_w++;
                    if (m_awvalid && m_awready) begin got_aw = 1'b1; wa = m_awaddr; aw_cnt++; end
                    if (m_wvalid && m_wready) begin got_w = 1'b1; wd = m_wdata; ws = m_wstrb; w_cnt++; end
                end
                @(posedge clk); #1;
                m_awready = got_aw ? 1'b0 : ($urandom_range(0, 1) == 1);
                m_wready  = got_w  ? 1'b0 : ($urandom_range(0, 1) == 1);
            end
            slave_mem[wa] = merge(slv_rd(wa), wd, ws);
            repeat (int'($urandom_range(0, 2))) begin @(posedge clk); #1; end
            m_bvalid = 1'b1; m_bresp = wa[7] ? 2'b10 : 2'b00;
            n = 0;
            do begin @(negedge clk); n++; end while (!m_bready && n < BUDGET);
            if (!m_bready) chk("slv_bready_timeout", 32'd1, 32'd0);
            @(posedge clk); #1 m_bvalid = 1'b0;
        end
    end

    // Responses and address-ready may only reach the port that owns the transaction.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < 2; p++) begin
                if (s_rvalid[p])  chk("r_route", 32'(rd_busy[p]), 32'd1);
                if (s_bvalid[p])  chk("b_route", 32'(wr_busy[p]), 32'd1);
                if (s_arready[p]) chk("ar_route", 32'(s_arvalid[p]), 32'd1);
            end
        end
    end

    task automatic do_read(input int p, input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] r, output bit ok);
        int n;
        ok = 1'b0; d = 32'd0; r = 2'd0; n = 0;
        s_arvalid[p] = 1'b1; s_araddr[p] = a; s_arprot[p] = 3'(p);
        forever begin @(negedge clk); if (s_arready[p] || rd_abort || n >= BUDGET) break; n++; end
        if (!s_arready[p]) begin
            if (!rd_abort) chk("ar_timeout", 32'd1, 32'd0);
            s_arvalid[p] = 1'b0;
            return;
        end
        @(posedge clk); #1 s_arvalid[p] = 1'b0; s_rready[p] = 1'b1; rd_busy[p] = 1'b1;
        n = 0;
        forever begin @(negedge clk); if (s_rvalid[p] || rd_abort || n >= BUDGET) break; n++; end
        if (s_rvalid[p]) begin
            d = s_rdata[p]; r = s_rresp[p]; ok = 1'b1;
            @(posedge clk); #1;
        end else if (!rd_abort) begin
            chk("r_timeout", 32'd1, 32'd0);
        end
        s_rready[p] = 1'b0; rd_busy[p] = 1'b0;
    endtask

    task automatic send_aw(input int p, input logic [31:0] a, input int lag, output bit ok);
        int n;
        ok = 1'b0; n = 0;
        repeat (lag) begin @(posedge clk); #1; end
        s_awvalid[p] = 1'b1; s_awaddr[p] = a; s_awprot[p] = 3'd0;
        forever begin @(negedge clk); if (s_awready[p] || n >= BUDGET) break; n++; end
        if (s_awready[p]) begin @(posedge clk); #1 ok = 1'b1; end
        else chk("aw_timeout", 32'd1, 32'd0);
        s_awvalid[p] = 1'b0;
    endtask

    task automatic send_w(input int p, input logic [31:0] d, input logic [3:0] s,
                          input int lag, output bit ok);
        int n;
        ok = 1'b0; n = 0;
        repeat (lag) begin @(posedge clk); #1; end
        s_wvalid[p] = 1'b1; s_wdata[p] = d; s_wstrb[p] = s;
        forever begin @(negedge clk); if (s_wready[p] || n >= BUDGET) break; n++; end
        if (s_wready[p]) begin @(posedge clk); #1 ok = 1'b1; end
        else chk("w_timeout", 32'd1, 32'd0);
        s_wvalid[p] = 1'b0;
    endtask

    // Read with model check; completion order is logged for arbitration checks.
    task automatic rd_chk(input int p, input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] r);
        bit ok;
        do_read(p, a, d, r, ok);
        if (ok) begin
            rd_order.push_back(p);
            chk("rd_data", d, ref_rd(a));
            chk("rd_resp", 32'(r), a[6] ? 32'd2 : 32'd0);
        end
    endtask

    task automatic wr_chk(input int p, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int aw_lag, input int w_lag);
        bit ok_aw, ok_w;
        int n;
        fork
            send_aw(p, a, aw_lag, ok_aw);
            send_w(p, d, s, w_lag, ok_w);
        join
        if (!(ok_aw && ok_w)) return;
        wr_busy[p] = 1'b1; s_bready[p] = 1'b1; n = 0;
        forever begin @(negedge clk); if (s_bvalid[p] || n >= BUDGET) break; n++; end
        if (s_bvalid[p]) begin
            chk("wr_resp", 32'(s_bresp[p]), a[7] ? 32'd2 : 32'd0);
            ref_mem[a] = merge(ref_rd(a), d, s);
            @(posedge clk); #1;
        end else begin
            chk("b_timeout", 32'd1, 32'd0);
        end
        s_bready[p] = 1'b0; wr_busy[p] = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_outs", 32'(all_vr), 32'd0);
        chk("rst_grants", {30'd0, rd_grant, wr_grant}, 32'd3);
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic rand_ops(input int p, input int cnt);
        logic [31:0] a, d;
        logic [1:0] r;
        for (int i = 0; i < cnt; i++) begin
            a = 32'(p * 256) + 32'($urandom_range(0, 63) * 4);
            if ($urandom_range(0, 1) == 1) rd_chk(p, a, d, r);
            else wr_chk(p, a, $urandom, 4'($urandom_range(1, 15)),
                        int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0] r;
        int c_aw, c_w, c_ar, rem0, rem1, last, win, n;
        bit ok;
        for (int p = 0; p < 2; p++) begin
            s_awvalid[p] = 1'b0; s_wvalid[p] = 1'b0; s_bready[p] = 1'b0;
            s_arvalid[p] = 1'b0; s_rready[p] = 1'b0;
            s_awaddr[p] = 32'd0; s_wdata[p] = 32'd0; s_araddr[p] = 32'd0;
            s_awprot[p] = 3'd0; s_arprot[p] = 3'd0; s_wstrb[p] = 4'd0;
            rd_busy[p] = 1'b0; wr_busy[p] = 1'b0;
        end
        apply_reset();

        slave_mem[32'h8] = 32'h0000_1234; ref_mem[32'h8] = 32'h0000_1234;
        rd_chk(0, 32'h8, d, r);
        chk("t1_rdata", d, 32'h0000_1234);
        chk("t1_rresp", 32'(r), 32'd0);
        chk("t1_rd_grant", 32'(rd_grant), 32'd0);

        apply_reset();
        rd_order.delete();
        fork
            for (int k = 0; k < 4; k++) rd_chk(0, 32'h0000, d, r);
            begin
                logic [31:0] d1;
                logic [1:0] r1;
                for (int k = 0; k < 4; k++) rd_chk(1, 32'h1000, d1, r1);
            end
        join
        chk("t2_count", 32'(rd_order.size()), 32'd8);
        rem0 = 4; rem1 = 4; last = 1;
        for (int k = 0; k < 8 && k < rd_order.size(); k++) begin
            if (rem0 > 0 && rem1 > 0) win = FIXED ? 0 : 1 - last;
            else win = (rem0 > 0) ? 0 : 1;
            chk("t2_order", 32'(rd_order[k]), 32'(win));
            if (win == 0) rem0--; else rem1--;
            last = win;
        end

        c_aw = aw_cnt; c_w = w_cnt;
        wr_chk(1, 32'h2000, 32'h0000_00A5, 4'hF, 2, 0);
        chk("t3_aw_cnt", 32'(aw_cnt - c_aw), 32'd1);
        chk("t3_w_cnt", 32'(w_cnt - c_w), 32'd1);
        chk("t3_wr_grant", 32'(wr_grant), 32'd1);
        rd_chk(1, 32'h2000, d, r);
        chk("t3_readback", d, 32'h0000_00A5);

        fork
            rd_chk(0, 32'h0044, d, r);
            wr_chk(1, 32'h0180, 32'hDEAD_BEEF, 4'h5, 0, 1);
        join
        chk("t4_rd_grant", 32'(rd_grant), 32'd0);
        chk("t4_wr_grant", 32'(wr_grant), 32'd1);

        c_ar = ar_cnt; rd_hold = 1'b1;
        fork
            do_read(0, 32'h0040, d, r, ok);
            begin
                n = 0;
                while (ar_cnt == c_ar && n < BUDGET) begin @(negedge clk); n++; end
                chk("t5_ar_seen", 32'(ar_cnt - c_ar), 32'd1);
                @(posedge clk); #3 rst_n = 1'b0;
                #1;
                chk("t5_async_outs", 32'(all_vr), 32'd0);
                chk("t5_async_grants", {30'd0, rd_grant, wr_grant}, 32'd3);
                rd_abort = 1'b1;
            end
        join
        chk("t5_aborted", 32'(ok), 32'd0);
        rd_drop = 1'b1; rd_hold = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 rd_drop = 1'b0; rd_abort = 1'b0;
        rd_chk(1, 32'h0104, d, r);
        chk("t5_rd_grant", 32'(rd_grant), 32'd1);

        fork
            rand_ops(0, 30);
            rand_ops(1, 30);
        join
        chk("dup_aw", 32'(dup_aw), 32'd0);
        chk("dup_w", 32'(dup_w), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
